// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner: shared sampling tick, per-channel sync, debounce,
// press/release/long-press/auto-repeat pulses. release/repeat are keywords, hence btn_ prefix.
module btn_debounce_chan #(
    parameter int STABLE_TICKS = 2,
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic pin,
    output logic level,
    output logic press,
    output logic rel,
    output logic long_p,
    output logic rep_p
);
    localparam int AW       = $clog2(STABLE_TICKS + 1);
    localparam int HW       = $clog2(LONG_TICKS + 1);
    localparam int RW       = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
    localparam int REP_LAST = (REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0;

    typedef enum logic [1:0] {RELEASED, PRESSED, LONG} state_t;

    state_t          state;
    logic [1:0]      sync;
    logic [AW-1:0]   agree;
    logic [HW-1:0]   hold;
    logic [RW-1:0]   rep;
    logic            flip;

    // The tick that completes the run of disagreeing samples flips the level.
    assign flip = tick && (sync[1] != level) && (agree == AW'(STABLE_TICKS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= RELEASED;
            sync   <= '0;
            agree  <= '0;
            hold   <= '0;
            rep    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
            rel    <= 1'b0;
            long_p <= 1'b0;
            rep_p  <= 1'b0;
        end else begin
            sync   <= {sync[0], pin ^ ACTIVE_LOW};
            press  <= 1'b0;
            rel    <= 1'b0;
            long_p <= 1'b0;
            rep_p  <= 1'b0;
            if (tick) begin
                if (sync[1] == level) agree <= '0;
                else if (flip) begin
                    agree <= '0;
                    level <= ~level;
                end else agree <= agree + 1'b1;

                // A fall wins over long/repeat on the same tick.
                if (flip && level) begin
                    state <= RELEASED;
                    rel   <= 1'b1;
                    hold  <= '0;
                    rep   <= '0;
                end else if (flip) begin
                    state <= PRESSED;
                    press <= 1'b1;
                    hold  <= '0;
                end else begin
                    case (state)
                        PRESSED: begin
                            if (hold == HW'(LONG_TICKS - 1)) begin
                                state  <= LONG;
                                long_p <= 1'b1;
                                hold   <= '0;
                                rep    <= '0;
                            end else hold <= hold + 1'b1;
                        end
                        LONG: begin
                            if (REPEAT_TICKS != 0) begin
                                if (rep == RW'(REP_LAST)) begin
                                    rep_p <= 1'b1;
                                    rep   <= '0;
                                end else rep <= rep + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

module btn_debounce_multi #(
    parameter int N_BTN        = 4,
    parameter int TICK_CNT     = 1000000,
    parameter int STABLE_TICKS = 2,
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] long_press,
    output logic [N_BTN-1:0] btn_repeat,
    output logic             any_event
);
    localparam int TW = $clog2(TICK_CNT);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(TICK_CNT - 1));

    always_ff @(posedge clock) begin
        if (reset || tick) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + 1'b1;
    end

    btn_debounce_chan #(
        .STABLE_TICKS(STABLE_TICKS),
        .LONG_TICKS  (LONG_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS),
        .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_ch [N_BTN-1:0] (
        .clock (clock),
        .reset (reset),
        .tick  (tick),
        .pin   (btn_in),
        .level (btn_level),
        .press (press),
        .rel   (btn_release),
        .long_p(long_press),
        .rep_p (btn_repeat)
    );

    always_ff @(posedge clock) begin
        if (reset) any_event <= 1'b0;
        else       any_event <= |{press, btn_release, long_press, btn_repeat};
    end
endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: two instances (active-high with repeat, active-low without),
// directed scenarios plus random pins, all compared against a tick-level reference model.
module tb_btn_debounce_multi;
    localparam int TICK = 4, STB = 2, LNG = 5;

    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] pa = '0;
    logic [1:0] pb = 2'b11;
    logic [3:0] lva, pra, rla, lga, rpa;
    logic [1:0] lvb, prb, rlb, lgb, rpb;
    logic       anya, anyb;

    always #5 clk = ~clk;

    btn_debounce_multi #(.N_BTN(4), .TICK_CNT(TICK), .STABLE_TICKS(STB), .LONG_TICKS(LNG),
                         .REPEAT_TICKS(2), .ACTIVE_LOW(1'b0)) ua (
        .clock(clk), .reset(rst), .btn_in(pa), .btn_level(lva), .press(pra),
        .btn_release(rla), .long_press(lga), .btn_repeat(rpa), .any_event(anya));

    btn_debounce_multi #(.N_BTN(2), .TICK_CNT(TICK), .STABLE_TICKS(STB), .LONG_TICKS(LNG),
                         .REPEAT_TICKS(0), .ACTIVE_LOW(1'b1)) ub (
        .clock(clk), .reset(rst), .btn_in(pb), .btn_level(lvb), .press(prb),
        .btn_release(rlb), .long_press(lgb), .btn_repeat(rpb), .any_event(anyb));

    int total = 0, bad = 0, cyc_n = 0;

    // Reference model: channels 0..3 are ua, 4..5 are ub; works on logical "pressed" values.
    bit   m_lvl[6], m_p1[6], m_p2[6];
    int   m_run[6], m_tsp[6], m_edges;
    logic [5:0] e_prs, e_rel, e_lng, e_rpt, lv_prev;
    logic e_anya, e_anyb;
    int   n_prs[6], n_rel[6], n_lng[6], n_rpt[6], n_rise[6];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input logic [5:0] pr);
        logic [5:0] prev;
        bit samp;
        int rp;
        prev  = e_prs | e_rel | e_lng | e_rpt;
        e_prs = '0; e_rel = '0; e_lng = '0; e_rpt = '0;
        if (r) begin
            e_anya = 1'b0; e_anyb = 1'b0; m_edges = 0;
            for (int c = 0; c < 6; c++) begin
                m_lvl[c] = 0; m_p1[c] = 0; m_p2[c] = 0; m_run[c] = 0; m_tsp[c] = 0;
            end
        end else begin
            e_anya = |prev[3:0];
            e_anyb = |prev[5:4];
            m_edges++;
            for (int c = 0; c < 6; c++) begin
                // the pin value two edges ago is what the debouncer sees now
                samp = m_p2[c]; m_p2[c] = m_p1[c]; m_p1[c] = pr[c];
                rp = (c < 4) ? 2 : 0;
                if (m_edges % TICK == 0) begin
                    m_run[c] = (samp != m_lvl[c]) ? m_run[c] + 1 : 0;
                    if (m_run[c] == STB) begin
                        m_run[c] = 0;
                        m_lvl[c] = !m_lvl[c];
                        if (m_lvl[c]) begin e_prs[c] = 1'b1; m_tsp[c] = 0; end
                        else e_rel[c] = 1'b1;
                    end else if (m_lvl[c]) begin
                        m_tsp[c]++;
                        if (m_tsp[c] == LNG) e_lng[c] = 1'b1;
                        else if (rp != 0 && m_tsp[c] > LNG && (m_tsp[c] - LNG) % rp == 0)
                            e_rpt[c] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic clr();
        for (int c = 0; c < 6; c++) begin
            n_prs[c] = 0; n_rel[c] = 0; n_lng[c] = 0; n_rpt[c] = 0; n_rise[c] = 0;
        end
    endtask

    task automatic cyc();
        logic [5:0] e_lv, lv, pr, rl, lg, rp;
        @(posedge clk);
        #1;
        model_edge(rst, {~pb, pa});
        for (int c = 0; c < 6; c++) e_lv[c] = m_lvl[c];
        lv = {lvb, lva}; pr = {prb, pra}; rl = {rlb, rla}; lg = {lgb, lga}; rp = {rpb, rpa};
        chk("level", lv, e_lv);
        chk("press", pr, e_prs);
        chk("release", rl, e_rel);
        chk("long", lg, e_lng);
        chk("repeat", rp, e_rpt);
        chk("any", {anyb, anya}, {e_anyb, e_anya});
        cyc_n++;
        for (int c = 0; c < 6; c++) begin
            n_prs[c] += pr[c]; n_rel[c] += rl[c]; n_lng[c] += lg[c]; n_rpt[c] += rp[c];
            n_rise[c] += (lv[c] && !lv_prev[c]) ? 1 : 0;
        end
        lv_prev = lv;
    endtask

    initial begin
        int n, t_p, t_l, r1, r2, q;
        bit seen;
        e_prs = '0; e_rel = '0; e_lng = '0; e_rpt = '0; lv_prev = '0;
        clr();
        repeat (3) cyc();
        chk("rst_level", {lvb, lva}, 0);
        chk("rst_pulses", {prb, pra} | {rlb, rla} | {lgb, lga} | {rpb, rpa}, 0);
        chk("rst_any", {anyb, anya}, 0);
        rst = 1'b0;

        // active-low pins idle high: nothing happens
        clr();
        repeat (40) cyc();
        chk("al_idle", n_prs[4] + n_prs[5], 0);

        // clean press on ch0
        clr();
        pa[0] = 1'b1;
        n = 0;
        while (!lva[0] && n < 50) begin cyc(); n++; end
        chk("latency_ok", (n >= 1 && n <= STB * TICK + 2) ? 1 : 0, 1);
        repeat (200 - n) cyc();
        chk("c0_press", n_prs[0], 1);
        chk("others_quiet", n_rise[1] + n_rise[2] + n_rise[3] + n_rise[4] + n_rise[5], 0);
        pa[0] = 1'b0;
        repeat (30) cyc();
        chk("c0_release", n_rel[0], 1);

        // bounce on ch1, then settle pressed
        clr();
        for (int i = 0; i < 30; i++) begin pa[1] = ~pa[1]; cyc(); end
        pa[1] = 1'b1;
        repeat (40) cyc();
        chk("bounce_press", n_prs[1], 1);
        chk("bounce_rise", n_rise[1], 1);
        pa[1] = 1'b0;
        repeat (20) cyc();

        // one-tick glitch on ch2
        clr();
        pa[2] = 1'b1;
        repeat (TICK) cyc();
        pa[2] = 1'b0;
        repeat (20) cyc();
        chk("glitch", n_prs[2] + n_rel[2] + n_lng[2] + n_rpt[2] + n_rise[2], 0);

        // long press and repeat on ch3
        clr();
        pa[3] = 1'b1;
        t_p = -1000; t_l = -1000; r1 = -1; r2 = -1; n = 0;
        while (r2 < 0 && n < 200) begin
            cyc(); n++;
            if (pra[3]) t_p = cyc_n;
            if (lga[3]) t_l = cyc_n;
            if (rpa[3]) begin if (r1 < 0) r1 = cyc_n; else r2 = cyc_n; end
        end
        chk("long_delay", t_l - t_p, LNG * TICK);
        chk("rep1_delay", r1 - t_l, 2 * TICK);
        chk("rep2_delay", r2 - r1, 2 * TICK);
        clr();
        pa[3] = 1'b0;
        seen = 0; q = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (seen && (lga[3] || rpa[3])) q++;
            if (rla[3]) seen = 1;
        end
        chk("c3_release", n_rel[3], 1);
        chk("c3_quiet_after", q, 0);

        // active-low, repeat disabled: hold 100+ ticks
        clr();
        pb[0] = 1'b0;
        repeat (420) cyc();
        chk("b_press", n_prs[4], 1);
        chk("b_long", n_lng[4], 1);
        chk("b_repeat", n_rpt[4], 0);
        pb[0] = 1'b1;
        repeat (20) cyc();
        chk("b_release", n_rel[4], 1);

        // reset while ch0 is in LONG
        clr();
        pa[0] = 1'b1;
        repeat (40) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_mid_level", lva[0], 0);
        chk("rst_mid_norel", rla[0], 0);
        n = 0;
        while (!pra[0] && n < 50) begin cyc(); n++; end
        chk("repress_ok", (n <= STB * TICK + 2) ? 1 : 0, 1);
        pa[0] = 1'b0;
        repeat (20) cyc();

        // random pins with occasional reset
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 4; c++) if ($urandom_range(0, 15) == 0) pa[c] = ~pa[c];
            for (int c = 0; c < 2; c++) if ($urandom_range(0, 15) == 0) pb[c] = ~pb[c];
            rst = ($urandom_range(0, 399) == 0);
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised multi-channel push-button conditioner. It replaces the single-channel, rising-edge-only debouncer with N channels that share one sampling timer. Each channel provides a selectable input polarity, a configurable stability count, press and release pulses, a long-press pulse and auto-repeat. It sits between the board button pins and the user-interface logic, such as mode FSMs or counters, in the one-clock system domain.

## Interface
- N_BTN, 4, number of button channels (≥1)
- TICK_CNT, 1000000, clock cycles per sampling tick (10 ms at 100 MHz; ≥2; use 4 in simulation)
- STABLE_TICKS, 2, consecutive tick samples that must disagree with the current level before it flips (≥1)
- LONG_TICKS, 100, ticks a press must be held before long_press fires (≥1)
- REPEAT_TICKS, 20, ticks between repeat pulses after long_press (0 = repeat disabled)
- ACTIVE_LOW, 0, 1 = pin reads 0 when pressed (input inverted before synchroniser)
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- btn_in  input  N_BTN  raw asynchronous button pins
- btn_level  output  N_BTN  debounced pressed state (1 = pressed)
- press  output  N_BTN  1-cycle pulse on debounced press
- release  output  N_BTN  1-cycle pulse on debounced release
- long_press  output  N_BTN  1-cycle pulse when hold reaches LONG_TICKS
- repeat  output  N_BTN  1-cycle pulse every REPEAT_TICKS after long_press
- any_event  output  1  registered OR of all press/release/long_press/repeat bits of the previous cycle

## Operation
- Tick timer: one shared counter runs 0..TICK_CNT-1 and wraps to 0. tick is internal and high for one cycle when the counter equals TICK_CNT-1. Width is $clog2(TICK_CNT).
- Synchroniser: each channel inverts btn_in when ACTIVE_LOW=1, then passes it through 2 flops. Flops reset to 0 (released).
- Debounce: on a tick, if the synchronised sample ≠ btn_level[i], the channel's agree counter increments. Otherwise the agree counter clears.
  - When the increment would reach STABLE_TICKS, btn_level[i] toggles and the agree counter clears.
  - Between ticks the agree counter holds.
- Per-channel FSM, evaluated only on ticks:
  - RELEASED: when btn_level rises, go to PRESSED, pulse press, clear hold_cnt.
  - PRESSED: each tick with the level still 1 increments hold_cnt. When hold_cnt reaches LONG_TICKS, go to LONG, pulse long_press, clear rep_cnt.
  - LONG: each tick increments rep_cnt. When rep_cnt reaches REPEAT_TICKS (and REPEAT_TICKS≠0), pulse repeat and clear rep_cnt.
  - Any state, level falls: go to RELEASED, pulse release, clear hold_cnt and rep_cnt.
- Priority: a level fall on a tick beats long_press and repeat on that same tick, so the pulse is release only. The press tick does not count toward hold_cnt.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Counter widths: agree $clog2(STABLE_TICKS+1), hold $clog2(LONG_TICKS+1), rep $clog2(REPEAT_TICKS+1). No counter wraps; each clears as described.

## Timing
- Reset: all outputs are 0, the tick counter is 0, all FSMs are RELEASED, and sync flops and internal counters are 0. Reset asserted mid-press forces immediate RELEASED with no release pulse.
- press and release are registered on the same edge that updates btn_level. press[i] is high in the first cycle btn_level[i] reads 1, and release[i] in the first cycle it reads 0.
- Pin-to-level latency for a clean edge: the 2-cycle synchroniser plus time to the next tick, plus (STABLE_TICKS-1)·TICK_CNT cycles. The bound is ≤ STABLE_TICKS·TICK_CNT+2 cycles.
- long_press fires exactly LONG_TICKS·TICK_CNT cycles after press. Each repeat fires REPEAT_TICKS·TICK_CNT cycles after the previous long_press or repeat.
- Every pulse output is exactly 1 cycle wide. any_event lags the pulses by 1 cycle.
- Glitches that do not persist for STABLE_TICKS consecutive tick samples never change btn_level.

## Test plan
- Clean press, TICK_CNT=4, STABLE_TICKS=2, ch0 held high for 200 cycles -> press[0] once; btn_level[0]=1 within ≤10 cycles of the pin edge; no other channel toggles; any_event high 1 cycle after press.
- Bounce: ch1 toggles every cycle for 30 cycles, then settles at 1 -> btn_level[1] has exactly one 0→1 transition and press[1] fires exactly one pulse, after settling. A 1-tick-wide glitch on ch2 -> no output activity.
- Long press and repeat, LONG_TICKS=5, REPEAT_TICKS=2, TICK_CNT=4: long_press fires 20 cycles after press, then repeat every 8 cycles. Release after 2 repeats -> release pulse; repeat and long_press stay 0 afterwards.
- REPEAT_TICKS=0, hold 100 ticks -> exactly one long_press and zero repeat pulses.
- ACTIVE_LOW=1, all pins idle at 1 after reset -> no press. Pin driven to 0 -> press; pin back to 1 -> release.
- Reset while ch0 is in LONG -> btn_level=0 on the next cycle and no release pulse. With the pin still pressed after reset, a new press fires ≤ STABLE_TICKS·TICK_CNT+2 cycles after reset deasserts.
